// File: rtl/dht_responder.sv
// dht_responder: sensor end of the DHT-style single-wire protocol.
// Detects the host start pulse, answers with the 80/80 us presence handshake,
// then shifts out a 40-bit frame MSB first with pulse-width-coded bits.
// Optional feature: define DHT_AUTO_CSUM_EN to replace frame byte [7:0] with
// the mod-256 sum of the upper four bytes at latch time.
module dht_responder #(
    parameter int unsigned CLK_PER_US   = 50,
    parameter int unsigned START_MIN_US = 500,
    parameter int unsigned TGO_US       = 30
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic        data_in,
    output logic        data_oe,
    input  logic [39:0] frame_in,
    input  logic        frame_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CW = 17;

    // Terminal counts: a phase of N us ends when the counter reaches N*CLK_PER_US-1,
    // so the phase lasts exactly N*CLK_PER_US clocks.
    localparam logic [CW-1:0] T_START = CW'(START_MIN_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_TGO   = CW'(TGO_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_RESP  = CW'(80 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_BLOW  = CW'(50 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_B0    = CW'(26 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_B1    = CW'(70 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_END   = CW'(50 * CLK_PER_US - 1);
    // Collision fires once the line has been seen low for more than 2 us.
    localparam logic [CW-1:0] T_COLL  = CW'(2 * CLK_PER_US);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_RELEASE,
        S_WAIT_NOACK,
        S_GO_DELAY,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW,
        S_FINISH
    } state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_lcnt;
    logic [39:0]   r_sh;
    logic [5:0]    r_idx;
    logic          r_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_ds;
    logic          w_coll;
    logic [39:0]   w_latch;

    assign w_ds   = r_sync[1];
    assign w_coll = !w_ds && (r_lcnt >= T_COLL);

`ifdef DHT_AUTO_CSUM_EN
    logic [7:0] w_csum;
    assign w_csum  = frame_in[39:32] + frame_in[31:24] + frame_in[23:16] + frame_in[15:8];
    assign w_latch = {frame_in[39:8], w_csum};
`else
    assign w_latch = frame_in;
`endif

    assign data_oe = r_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

    // Two-flop synchronizer for the asynchronous line level; idles high.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], data_in};
        end
    end

    // Protocol FSM with phase counter, collision low-time counter and frame shifter.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lcnt  <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
            r_lcnt <= w_ds ? '0 : ((r_lcnt == '1) ? r_lcnt : r_lcnt + 1'b1);

            case (r_state)
                S_IDLE: begin
                    r_oe <= 1'b0;
                    if (!w_ds) begin
                        r_state <= S_START_LOW;
                        r_cnt   <= '0;
                    end
                end
                S_START_LOW: begin
                    if (w_ds) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt >= T_START) begin
                        if (frame_valid) begin
                            r_sh    <= w_latch;
                            r_busy  <= 1'b1;
                            r_state <= S_WAIT_RELEASE;
                        end else begin
                            r_state <= S_WAIT_NOACK;
                        end
                    end
                end
                S_WAIT_NOACK: begin
                    if (w_ds) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (w_ds) begin
                        r_state <= S_GO_DELAY;
                        r_cnt   <= '0;
                    end
                end
                S_GO_DELAY: begin
                    if (r_cnt >= T_TGO) begin
                        r_state <= S_RESP_LOW;
                        r_oe    <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_RESP_LOW: begin
                    if (r_cnt >= T_RESP) begin
                        r_state <= S_RESP_HIGH;
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_lcnt  <= '0;
                    end
                end
                S_RESP_HIGH: begin
                    if (w_coll) begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (r_cnt >= T_RESP) begin
                        r_state <= S_BIT_LOW;
                        r_oe    <= 1'b1;
                        r_idx   <= 6'd39;
                        r_cnt   <= '0;
                    end
                end
                S_BIT_LOW: begin
                    if (r_cnt >= T_BLOW) begin
                        r_state <= S_BIT_HIGH;
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_lcnt  <= '0;
                    end
                end
                S_BIT_HIGH: begin
                    if (w_coll) begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (r_cnt >= (r_sh[39] ? T_B1 : T_B0)) begin
                        r_sh    <= {r_sh[38:0], 1'b0};
                        r_idx   <= r_idx - 6'd1;
                        r_oe    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= (r_idx == '0) ? S_END_LOW : S_BIT_LOW;
                    end
                end
                S_END_LOW: begin
                    if (r_cnt >= T_END) begin
                        r_state <= S_FINISH;
                        r_oe    <= 1'b0;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_responder.sv
// Bench for dht_responder: plays the host on the shared line, decodes the
// responder's pulse train and compares it with a segment-level model of the frame.
module tb_dht_responder;

    localparam int unsigned C    = 3;
    localparam int unsigned SMIN = 100;
    localparam int unsigned TGO  = 30;
    localparam int unsigned NSEG = 83;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_low = 1'b0;
    logic        ext_low = 1'b0;
    logic        data_in;
    logic        data_oe;
    logic [39:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    // Open-drain line: low if anyone pulls it.
    assign data_in = !(data_oe || host_low || ext_low);

    always #5 clk = ~clk;

    dht_responder #(
        .CLK_PER_US  (C),
        .START_MIN_US(SMIN),
        .TGO_US      (TGO)
    ) dut (
        .clk50M     (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_oe    (data_oe),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int vec = 0;
    int mis = 0;

    task automatic chk(input string name, input longint act, input longint want, input longint tol = 0);
        vec++;
        if (act < want - tol || act > want + tol) begin
            mis++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) +/-%0d", name, act, act, want, want, tol);
        end
    endtask

    // Model: what the wire must carry for a given frame_in.
    function automatic logic [39:0] wire_frame(input logic [39:0] f);
`ifdef DHT_AUTO_CSUM_EN
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return {f[39:8], 8'(s % 256)};
`else
        return f;
`endif
    endfunction

    // Model: expected run lengths of data_oe, alternating drive/release, starting with drive.
    int exp_q[$];
    task automatic build_segments(input logic [39:0] wf);
        exp_q.delete();
        exp_q.push_back(80 * C);
        exp_q.push_back(80 * C);
        for (int i = 39; i >= 0; i--) begin
            exp_q.push_back(50 * C);
            exp_q.push_back((wf[i] ? 70 : 26) * C);
        end
        exp_q.push_back(50 * C);
    endtask

    // Checker state: mode 0 = line must stay quiet, 1 = frame expected, 2 = don't care.
    int          mode = 0;
    bit          fin, started, quiet_bad;
    int          seg, run, gap, tot;
    logic        lvl;
    logic [39:0] rx;
    int          done_cnt = 0;
    int          err_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (mode == 0) begin
            if (data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) quiet_bad = 1;
        end else if (mode == 1 && !fin) begin
            if (!started) begin
                if (data_oe === 1'b1) begin
                    started = 1;
                    chk("go_delay", gap, TGO * C + 3, 1);
                    run = 1;
                    lvl = 1'b1;
                end else begin
                    gap++;
                end
            end else if (data_oe === lvl) begin
                run++;
            end else begin
                chk($sformatf("seg%0d_len", seg), run, exp_q[seg], 1);
                chk($sformatf("seg%0d_busy", seg), busy, 1);
                if (seg >= 3 && seg % 2 == 1) rx = {rx[38:0], run > 48 * C};
                tot += run;
                seg++;
                lvl = data_oe;
                run = 1;
                if (seg == NSEG) fin = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_oe(input logic lv, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 * C; i++) begin
            @(negedge clk);
            if (data_oe === lv) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_toggles(input int n, output bit ok);
        ok = 1;
        for (int k = 0; k < n && ok; k++) wait_oe((k % 2 == 0) ? 1'b1 : 1'b0, ok);
    endtask

    task automatic start_valid(input logic [39:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        mode        = 2;
        host_low    = 1'b1;
        tick(int'($urandom_range(120, 200)) * C);
    endtask

    task automatic run_frame(input logic [39:0] f, input string tag, output logic [39:0] got);
        int d0, e0;
        build_segments(wire_frame(f));
        start_valid(f);
        chk({tag, "_busy_accept"}, busy, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        started = 0; fin = 0; seg = 0; gap = 0; tot = 0; rx = '0;
        mode = 1;
        host_low = 1'b0;
        tick(2);
        frame_in = {8'($urandom), $urandom};
        for (int i = 0; i < 6000 * C && !fin; i++) @(negedge clk);
        chk({tag, "_complete"}, fin, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_no_err"}, err_cnt - e0, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_oe_end"}, data_oe, 0);
        chk({tag, "_frame"}, rx, wire_frame(f));
        got = rx;
        mode = 0;
        quiet_bad = 0;
        tick(20 * C);
        chk({tag, "_post_quiet"}, quiet_bad, 0);
    endtask

    initial begin
        logic [39:0] got;
        logic [39:0] f;
        bit          ok;
        int          lat, d0, e0;
        logic        oe_at, busy_at;

        // Reset values
        tick(5);
        @(negedge clk);
        chk("rst_oe", data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick(1);
        rst = 1'b0;
        quiet_bad = 0;
        tick(10 * C);
        chk("idle_quiet", quiet_bad, 0);

        // Reference frame, literal-pinned value and total duration
        run_frame(40'h01F4_00FA_EF, "t1", got);
        chk("t1_literal", got, 40'h01F4_00FA_EF);
        chk("t1_total_clk", tot, 4086 * C, 2);

        // Short host low: glitch, no response
        mode = 0;
        quiet_bad = 0;
        host_low = 1'b1;
        tick(int'($urandom_range(20, 80)) * C);
        host_low = 1'b0;
        tick(100 * C);
        chk("glitch_quiet", quiet_bad, 0);

        // Sensor absent: start ignored
        frame_valid = 1'b0;
        quiet_bad = 0;
        host_low = 1'b1;
        tick(150 * C);
        host_low = 1'b0;
        tick(60 * C);
        chk("noack_quiet", quiet_bad, 0);

        // Valid start afterwards, checksum byte zeroed
        run_frame(40'h01F4_00FA_00, "t2", got);
`ifdef DHT_AUTO_CSUM_EN
        chk("t2_literal", got, 40'h01F4_00FA_EF);
`else
        chk("t2_literal", got, 40'h01F4_00FA_00);
`endif

        // Collision during BIT_HIGH of bit 20
        f = {8'($urandom), $urandom};
        start_valid(f);
        host_low = 1'b0;
        wait_toggles(42, ok);
        chk("col_reach", ok, 1);
        if (ok) begin
            tick(4);
            e0 = err_cnt;
            d0 = done_cnt;
            lat = 0;
            oe_at = 1'b1;
            busy_at = 1'b1;
            ext_low = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (err === 1'b1) begin
                    lat = i;
                    oe_at = data_oe;
                    busy_at = busy;
                    break;
                end
            end
            chk("col_err_latency", lat, 2 * C + 4, 1);
            chk("col_oe", oe_at, 0);
            chk("col_busy", busy_at, 0);
            tick((lat > 0 && lat < 5 * C) ? 5 * C - lat : 1);
            ext_low = 1'b0;
            tick(2);
            mode = 0;
            quiet_bad = 0;
            tick(50 * C);
            chk("col_quiet", quiet_bad, 0);
            chk("col_err_once", err_cnt - e0, 1);
            chk("col_no_done", done_cnt - d0, 0);
        end
        ext_low = 1'b0;
        mode = 0;
        tick(20 * C);
        run_frame({8'($urandom), $urandom}, "after_col", got);

        // Reset pulse during BIT_LOW of bit 10
        f = {8'($urandom), $urandom};
        start_valid(f);
        host_low = 1'b0;
        wait_toggles(61, ok);
        chk("rst_reach", ok, 1);
        d0 = done_cnt;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_oe", data_oe, 0);
        chk("midrst_busy", busy, 0);
        mode = 0;
        quiet_bad = 0;
        tick(100 * C);
        chk("midrst_quiet", quiet_bad, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        run_frame({8'($urandom), $urandom}, "after_rst", got);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dht_responder.md
# dht_responder

Single-wire humidity/temperature sensor responder: the sensor end of the same one-wire DHT-style protocol the `Humidity` block speaks as host on `Data_H`. It detects the host start pulse, answers with the presence handshake and shifts out a 40-bit frame with pulse-width-coded bits. It serves as an on-board sensor emulator for bench and bring-up, and can be strapped onto `Data_H` in place of a physical sensor.

## Interface
- `CLK_PER_US`, 50: clk50M cycles per microsecond.
- `START_MIN_US`, 500: minimum host low time, in µs, accepted as a start pulse.
- `TGO_US`, 30: delay from host release to the responder driving low.
- clk50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- data_in  in  1  sampled level of the shared data line (asynchronous).
- data_oe  out  1  1 = pull the line low (open-drain); 0 = release the line.
- frame_in  in  40  frame {hum[15:0], temp[15:0], csum[7:0]}; transmitted MSB (bit 39) first.
- frame_valid  in  1  1 = a frame is available; when 0 the responder ignores start pulses (sensor absent).
- busy  out  1  high from start acceptance until end of frame or abort.
- done  out  1  one-cycle pulse after the final END_LOW phase completes.
- err  out  1  one-cycle pulse on abort (collision).

## Operation
- data_in passes through a 2-flop synchronizer. All decisions use the synchronized level `ds`.
- One duration counter, reloaded on each state entry, counts in clocks: `N_us*CLK_PER_US`, saturating width ≥ 17 bits.
- States:
  - **IDLE**: data_oe=0. When `ds`=0, go to START_LOW and clear the counter.
  - **START_LOW**: count while `ds`=0.
    - `ds` rises before START_MIN_US: glitch, return to IDLE with no output activity.
    - Counter reaches START_MIN_US with frame_valid=1: latch frame_in into the 40-bit shift register, set busy=1, go to WAIT_RELEASE.
    - Counter reaches START_MIN_US with frame_valid=0: go to WAIT_RELEASE_NOACK. In that state, wait for `ds`=1, then return to IDLE.
  - **WAIT_RELEASE**: wait for `ds`=1, then go to GO_DELAY. The host low time is unbounded.
  - **GO_DELAY**: TGO_US released, then RESP_LOW.
  - **RESP_LOW**: data_oe=1 for 80 µs, then RESP_HIGH.
  - **RESP_HIGH**: data_oe=0 for 80 µs, then BIT_LOW with bit index 39.
  - **BIT_LOW**: data_oe=0→1 (drive low) for 50 µs, then BIT_HIGH.
  - **BIT_HIGH**: release the line for 26 µs if the current bit is 0, or 70 µs if it is 1.
    - At the end of the bit, shift left and decrement the index.
    - Index 0 done: go to END_LOW. Otherwise go to BIT_LOW.
  - **END_LOW**: drive low for 50 µs, release, pulse done, busy=0, go to IDLE.
- Collision: in RESP_HIGH or BIT_HIGH (line released), `ds`=0 for more than 2 µs continuously means abort. On abort: data_oe=0, pulse err, busy=0, go to IDLE. The low must persist the full 2 µs window before it counts, which masks synchronizer and edge latency.
- frame_in changes while busy have no effect; the frame is latched once per transaction.
- rst has priority over every state: IDLE, counter cleared, shift register cleared.

## Timing
- Reset values: data_oe=0, busy=0, done=0, err=0.
- Input-to-decision latency: 2 clocks (synchronizer), plus 1 clock for the state register.
- Release edge to first data_oe=1: TGO_US*CLK_PER_US + 3 clocks ±1.
- Phase durations are exact to ±1 clock: each phase lasts `N_us*CLK_PER_US` clocks.
- Total frame time after the go delay: 160 µs + 40×50 µs + Σ(26|70) µs + 50 µs.
- done asserts on the clock after data_oe falls to 0 at the end of END_LOW. busy deasserts on the same clock.
- A start pulse arriving while busy is not interpreted as a start. Only the collision rule applies.

## Configuration
- `DHT_AUTO_CSUM_EN` defined: at latch time, the transmitted byte [7:0] is replaced by `(f[39:32]+f[31:24]+f[23:16]+f[15:8]) mod 256`. frame_in[7:0] is ignored.
- `DHT_AUTO_CSUM_EN` undefined: all 40 bits are sent exactly as latched from frame_in, which allows bad-checksum injection for host-side tests.

## Test plan
- Host low 1000 µs, then release; frame_in=40'h01F4_00FA_EF, frame_valid=1 → 80/80 µs handshake followed by 40 bits decoded as 0x01F400FAEF (low 50 µs; high 26 µs for 0, 70 µs for 1). One done pulse, no err.
- Same stimulus with frame_in[7:0]=8'h00 → `DHT_AUTO_CSUM_EN` defined: 0xEF on the wire; undefined: 0x00 on the wire.
- Host low 200 µs, then release → data_oe stays 0 and busy stays 0 throughout.
- Host low 1000 µs with frame_valid=0 → no drive, busy stays 0. A subsequent valid start pulse is answered normally.
- External low of 5 µs injected during BIT_HIGH of bit 20 → err pulses once, data_oe=0 within 2 µs + 3 clocks, IDLE. The next start pulse yields a full correct frame.
- rst asserted for 1 clock mid-frame (bit 10) → data_oe=0 and busy=0 on the next clock, no done pulse. The responder recovers on the next start pulse.
